mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single memory port. Instruction fetch and data load/store both drive the MFA/MFC handshake toward the same RAM. The block grants one requester at a time and latches that requester's address, direction, size and write data onto the memory port. It routes the memory's MFC back only to the granted requester. It sits between the control-unit/MAR/MBR datapath and the RAM model.

## Interface
- AW, 32, address width
- DW, 32, data width
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- F_MFA  in  1  fetch request; held high until F_MFC seen
- F_ADDR  in  AW  fetch address
- F_WORD_BYTE  in  1  fetch size (1 = word)
- F_MFC  out  1  fetch completion
- D_MFA  in  1  data request; held high until D_MFC seen
- D_ADDR  in  AW  data address
- D_READ_WRITE  in  1  1 = read, 0 = write
- D_WORD_BYTE  in  1  data size
- D_WDATA  in  DW  store data
- D_MFC  out  1  data completion
- RDATA  out  DW  read data, common to both requesters
- M_MFA  out  1  memory request
- M_ADDR  out  AW  latched address
- M_READ_WRITE  out  1  latched direction
- M_WORD_BYTE  out  1  latched size
- M_WDATA  out  DW  latched store data
- M_MFC  in  1  memory completion (level)
- M_RDATA  in  DW  memory read data
- GRANT  out  2  one-hot owner: [0] = fetch, [1] = data

## Operation
- States: IDLE, GNT_F, GNT_D, RELEASE.
- IDLE:
  - If neither MFA is high, remain in IDLE.
  - If exactly one MFA is high, grant that requester.
  - If both are high, use the pick rule (see Configuration).
- On entry to a grant state, latch the winner's ADDR, size and WDATA into the M_* registers and assert M_MFA.
  - A fetch grant always sets M_READ_WRITE = 1.
  - A fetch grant leaves M_WDATA unchanged.
- Latched M_* fields hold constant for the whole grant, even if requester inputs change.
- GNT_x:
  - x_MFC = M_MFC, combinational.
  - The other requester's MFC is held at 0.
  - RDATA = M_RDATA, combinational.
  - Leave to RELEASE when x_MFA falls, whether after MFC or as an abort before it.
  - On leaving, M_MFA falls on the same edge.
- RELEASE:
  - M_MFA = 0 and both MFC outputs = 0.
  - Stay in RELEASE while M_MFC = 1, because memory MFC can stay up after MFA drops.
  - Go to IDLE when M_MFC = 0.
- A requester's MFA that is already high while the other requester owns the port waits; it is never dropped or lost.
- After RELEASE, there is no grant in the same cycle; IDLE always costs one cycle.

## Timing
- Reset (asynchronous, while Reset = 0):
  - State = IDLE.
  - M_MFA = 0, M_ADDR = 0, M_READ_WRITE = 0, M_WORD_BYTE = 0, M_WDATA = 0, GRANT = 0.
  - F_MFC = D_MFC = 0, RDATA = 0.
  - RR pointer = fetch-last, so data wins the first tie.
- Reset asserted mid-transaction: M_MFA drops immediately and the pending grant is discarded.
- Request latency: MFA sampled high in IDLE at edge k gives M_MFA = 1 and GRANT valid after edge k.
- MFC path: M_MFC to x_MFC is zero-cycle combinational.
- x_MFA low at edge j gives M_MFA = 0 after edge j.
- Minimum back-to-back occupancy: request cycle + memory latency + 2 cycles (RELEASE and IDLE).
- Invariants:
  - GRANT is one-hot or zero.
  - M_MFA = 1 only when GRANT ≠ 0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on a tie.
  - A 1-bit last-owner register updates at every grant.
  - On a tie, the requester that was not last served wins.
- MEM_ARB_RR_EN undefined: fixed priority, data beats fetch on every tie.
  - No pointer register is built.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, GNT_F, GNT_D, RELEASE);
  - the requester index constants REQ_F = 0 and REQ_D = 1.
- One sub-module, mem_arb_pick: combinational winner select from {F_MFA, D_MFA, last_owner}.
  - It holds the MEM_ARB_RR_EN conditional.
  - It is instantiated once.

## Test plan
- Reset mid-grant: state GNT_D with M_MFA = 1, Reset pulsed low → M_MFA = 0 immediately; on release, IDLE with all outputs 0.
- Fetch-only read: F_MFA = 1, F_ADDR = 0x40, memory returns MFC 3 cycles later with M_RDATA = 0xE3A01005 → M_ADDR = 0x40 and M_READ_WRITE = 1 one edge after the request; F_MFC high with RDATA = 0xE3A01005; D_MFC stays 0.
- Tie, fixed priority (MEM_ARB_RR_EN off): both MFA raised on the same edge → data served first; fetch granted after RELEASE + IDLE.
- Tie, round-robin (MEM_ARB_RR_EN on): both MFA held high, four transactions → GRANT sequence D, F, D, F.
- Sticky MFC: memory holds M_MFC = 1 for 3 cycles after D_MFA drops, while F_MFA is pending → arbiter stays in RELEASE for 3 cycles, M_MFA stays 0, F granted only after M_MFC = 0.
- Abort and stability:
  - Data write with D_WDATA = 0xDEADBEEF; D_ADDR changed during the grant → M_ADDR and M_WDATA keep the latched values.
  - D_MFA dropped before MFC → RELEASE, no D_MFC pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_F   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEM_ARB_RR_EN: ties go to the requester not served last; otherwise data always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_mfa_i,
  input  logic d_mfa_i,
  input  logic last_owner_i,
  output logic win_vld_o,
  output logic win_o
);

  always_comb begin
    win_vld_o = f_mfa_i | d_mfa_i;
    win_o     = d_mfa_i ? REQ_D : REQ_F;
`ifdef MEM_ARB_RR_EN
    if (f_mfa_i && d_mfa_i) begin
      win_o = (last_owner_i == REQ_F) ? REQ_D : REQ_F;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single RAM port to fetch or data, latching the winner's request fields.
// MEM_ARB_RR_EN selects round-robin tie breaking (default: data has fixed priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          F_MFA,
  input  logic [AW-1:0] F_ADDR,
  input  logic          F_WORD_BYTE,
  output logic          F_MFC,
  input  logic          D_MFA,
  input  logic [AW-1:0] D_ADDR,
  input  logic          D_READ_WRITE,
  input  logic          D_WORD_BYTE,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_MFC,
  output logic [DW-1:0] RDATA,
  output logic          M_MFA,
  output logic [AW-1:0] M_ADDR,
  output logic          M_READ_WRITE,
  output logic          M_WORD_BYTE,
  output logic [DW-1:0] M_WDATA,
  input  logic          M_MFC,
  input  logic [DW-1:0] M_RDATA,
  output logic [1:0]    GRANT
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic          m_rw_q, m_rw_d;
  logic          m_wb_q, m_wb_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          last_q;
  logic          win_vld, win;

  mem_arb_pick u_pick (
    .f_mfa_i      (F_MFA),
    .d_mfa_i      (D_MFA),
    .last_owner_i (last_q),
    .win_vld_o    (win_vld),
    .win_o        (win)
  );

`ifdef MEM_ARB_RR_EN
  logic last_d;

  assign last_d = (state_q == IDLE && win_vld) ? win : last_q;

  // Reset to fetch-last so the first tie goes to data.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) last_q <= REQ_F;
    else        last_q <= last_d;
  end
`else
  assign last_q = REQ_F;
`endif

  always_comb begin
    state_d   = state_q;
    m_addr_d  = m_addr_q;
    m_rw_d    = m_rw_q;
    m_wb_d    = m_wb_q;
    m_wdata_d = m_wdata_q;
    M_MFA     = 1'b0;
    GRANT     = 2'b00;
    F_MFC     = 1'b0;
    D_MFC     = 1'b0;
    RDATA     = '0;
    case (state_q)
      IDLE: begin
        if (win_vld && win == REQ_D) begin
          state_d   = GNT_D;
          m_addr_d  = D_ADDR;
          m_rw_d    = D_READ_WRITE;
          m_wb_d    = D_WORD_BYTE;
          m_wdata_d = D_WDATA;
        end else if (win_vld) begin
          // Fetch is always a read; store data register keeps its old value.
          state_d  = GNT_F;
          m_addr_d = F_ADDR;
          m_rw_d   = 1'b1;
          m_wb_d   = F_WORD_BYTE;
        end
      end
      GNT_F: begin
        M_MFA = 1'b1;
        GRANT = 2'b01;
        F_MFC = M_MFC;
        RDATA = M_RDATA;
        if (!F_MFA) state_d = RELEASE;
      end
      GNT_D: begin
        M_MFA = 1'b1;
        GRANT = 2'b10;
        D_MFC = M_MFC;
        RDATA = M_RDATA;
        if (!D_MFA) state_d = RELEASE;
      end
      RELEASE: begin
        // Memory may hold MFC after MFA drops; wait it out before re-arbitrating.
        if (!M_MFC) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      m_addr_q  <= '0;
      m_rw_q    <= 1'b0;
      m_wb_q    <= 1'b0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_addr_q  <= m_addr_d;
      m_rw_q    <= m_rw_d;
      m_wb_q    <= m_wb_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign M_ADDR       = m_addr_q;
  assign M_READ_WRITE = m_rw_q;
  assign M_WORD_BYTE  = m_wb_q;
  assign M_WDATA      = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected port contents are queued when a request is raised.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        F_MFA, F_WORD_BYTE, F_MFC;
  logic [31:0] F_ADDR;
  logic        D_MFA, D_READ_WRITE, D_WORD_BYTE, D_MFC;
  logic [31:0] D_ADDR, D_WDATA, RDATA;
  logic        M_MFA, M_READ_WRITE, M_WORD_BYTE, M_MFC;
  logic [31:0] M_ADDR, M_WDATA, M_RDATA;
  logic [1:0]  GRANT;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic        rw;
    logic        wb;
    logic [31:0] wdata;
  } port_t;

  port_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_wdata;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .F_MFA(F_MFA), .F_ADDR(F_ADDR), .F_WORD_BYTE(F_WORD_BYTE), .F_MFC(F_MFC),
    .D_MFA(D_MFA), .D_ADDR(D_ADDR), .D_READ_WRITE(D_READ_WRITE),
    .D_WORD_BYTE(D_WORD_BYTE), .D_WDATA(D_WDATA), .D_MFC(D_MFC),
    .RDATA(RDATA), .M_MFA(M_MFA), .M_ADDR(M_ADDR), .M_READ_WRITE(M_READ_WRITE),
    .M_WORD_BYTE(M_WORD_BYTE), .M_WDATA(M_WDATA), .M_MFC(M_MFC),
    .M_RDATA(M_RDATA), .GRANT(GRANT)
  );

  always #5 Clk = ~Clk;

  function automatic port_t port_obs();
    return {GRANT, M_ADDR, M_READ_WRITE, M_WORD_BYTE, M_WDATA};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (GRANT != 2'b00) begin
        ok = 1'b1;
        cyc = i + 1;
        break;
      end
    end
  endtask

  // Memory answers after lat cycles; the owner drops MFA on seeing MFC. M_MFC is left high.
  task automatic complete(input bit is_d, input int lat, input logic [31:0] rd,
                          output logic f_m, output logic d_m, output logic [31:0] r);
    repeat (lat) tick();
    M_RDATA = rd;
    M_MFC = 1'b1;
    #1;
    f_m = F_MFC;
    d_m = D_MFC;
    r = RDATA;
    if (is_d) D_MFA = 1'b0;
    else F_MFA = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    F_MFA = 0; F_ADDR = 0; F_WORD_BYTE = 0;
    D_MFA = 0; D_ADDR = 0; D_READ_WRITE = 0; D_WORD_BYTE = 0; D_WDATA = 0;
    M_MFC = 1'b1; M_RDATA = 32'hFFFF_FFFF;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if (port_obs() !== '0) begin
      n_bad++;
      $display("FAIL reset_port: got %h want 0", port_obs());
    end
    n_cmp++;
    if ({M_MFA, F_MFC, D_MFC, RDATA} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_outs: got mfa=%b fmfc=%b dmfc=%b rdata=%h want all 0", M_MFA, F_MFC, D_MFC, RDATA);
    end
    M_MFC = 1'b0;
    M_RDATA = 32'h0;
    exp_wdata = 32'h0;
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    bit ok; int cyc; logic f_m, d_m; logic [31:0] r;
    F_ADDR = 32'h40; F_WORD_BYTE = 1'b1; F_MFA = 1'b1;
    sb.push_back('{grant: 2'b01, addr: 32'h40, rw: 1'b1, wb: 1'b1, wdata: exp_wdata});
    wait_grant(4, ok, cyc);
    n_cmp++;
    if (!ok || cyc != 1) begin
      n_bad++;
      $display("FAIL fetch_latency: got ok=%0b cycles=%0d want 1 cycle", ok, cyc);
    end
    n_cmp++;
    begin
      port_t e = sb.pop_front();
      if (port_obs() !== e || M_MFA !== 1'b1) begin
        n_bad++;
        $display("FAIL fetch_port: got %h mfa=%b want %h mfa=1", port_obs(), M_MFA, e);
      end
    end
    complete(1'b0, 3, 32'hE3A01005, f_m, d_m, r);
    n_cmp++;
    if ({f_m, d_m, r} !== {1'b1, 1'b0, 32'hE3A01005}) begin
      n_bad++;
      $display("FAIL fetch_mfc: got f=%b d=%b rdata=%h want f=1 d=0 rdata=e3a01005", f_m, d_m, r);
    end
    n_cmp++;
    if ({M_MFA, F_MFC, D_MFC, GRANT, RDATA} !== 37'h0) begin
      n_bad++;
      $display("FAIL fetch_release: got mfa=%b fmfc=%b grant=%b rdata=%h want all 0", M_MFA, F_MFC, GRANT, RDATA);
    end
    M_MFC = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_tie();
    bit ok; int cyc; logic f_m, d_m; logic [31:0] r;
    F_ADDR = 32'h100; F_WORD_BYTE = 1'b0;
    D_ADDR = 32'h200; D_READ_WRITE = 1'b0; D_WORD_BYTE = 1'b1; D_WDATA = 32'h1122_3344;
    F_MFA = 1'b1; D_MFA = 1'b1;
    exp_wdata = 32'h1122_3344;
    sb.push_back('{grant: 2'b10, addr: 32'h200, rw: 1'b0, wb: 1'b1, wdata: exp_wdata});
    sb.push_back('{grant: 2'b01, addr: 32'h100, rw: 1'b1, wb: 1'b0, wdata: exp_wdata});
    wait_grant(4, ok, cyc);
    n_cmp++;
    begin
      port_t e = sb.pop_front();
      if (!ok || port_obs() !== e) begin
        n_bad++;
        $display("FAIL tie_first: got %h want %h", port_obs(), e);
      end
    end
    complete(1'b1, 1, 32'h0, f_m, d_m, r);
    n_cmp++;
    if ({f_m, d_m} !== 2'b01) begin
      n_bad++;
      $display("FAIL tie_d_mfc: got f=%b d=%b want f=0 d=1", f_m, d_m);
    end
    M_MFC = 1'b0;
    wait_grant(6, ok, cyc);
    n_cmp++;
    if (!ok || cyc != 2) begin
      n_bad++;
      $display("FAIL tie_gap: got ok=%0b cycles=%0d want 2", ok, cyc);
    end
    n_cmp++;
    begin
      port_t e = sb.pop_front();
      if (port_obs() !== e) begin
        n_bad++;
        $display("FAIL tie_second: got %h want %h", port_obs(), e);
      end
    end
    complete(1'b0, 1, 32'h5, f_m, d_m, r);
    M_MFC = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; logic f_m, d_m; logic [31:0] r; bit own_d;
    port_t e;
    F_ADDR = 32'h300; D_ADDR = 32'h400; D_READ_WRITE = 1'b1;
    F_MFA = 1'b1; D_MFA = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      e.grant = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      e.grant = 2'b10;
`endif
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      wait_grant(6, ok, cyc);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || GRANT !== e.grant) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got %b want %b", i, GRANT, e.grant);
      end
      own_d = GRANT[1];
      complete(own_d, 1, 32'h0, f_m, d_m, r);
      M_MFC = 1'b0;
      if (i < 3) begin
        if (own_d) D_MFA = 1'b1;
        else F_MFA = 1'b1;
      end else begin
        F_MFA = 1'b0; D_MFA = 1'b0;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_sticky_mfc();
    bit ok; int cyc; logic f_m, d_m; logic [31:0] r;
    D_ADDR = 32'h500; D_READ_WRITE = 1'b1; D_WORD_BYTE = 1'b1; D_WDATA = 32'hCAFE_0001;
    D_MFA = 1'b1;
    exp_wdata = 32'hCAFE_0001;
    sb.push_back('{grant: 2'b10, addr: 32'h500, rw: 1'b1, wb: 1'b1, wdata: exp_wdata});
    sb.push_back('{grant: 2'b01, addr: 32'h600, rw: 1'b1, wb: 1'b1, wdata: exp_wdata});
    wait_grant(4, ok, cyc);
    n_cmp++;
    begin
      port_t e = sb.pop_front();
      if (!ok || port_obs() !== e) begin
        n_bad++;
        $display("FAIL sticky_d: got %h want %h", port_obs(), e);
      end
    end
    F_ADDR = 32'h600; F_WORD_BYTE = 1'b1; F_MFA = 1'b1;
    complete(1'b1, 2, 32'h77, f_m, d_m, r);
    n_cmp++;
    if ({f_m, d_m, r} !== {1'b0, 1'b1, 32'h77}) begin
      n_bad++;
      $display("FAIL sticky_mfc_route: got f=%b d=%b rdata=%h want f=0 d=1 rdata=77", f_m, d_m, r);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({M_MFA, GRANT, F_MFC, D_MFC} !== 5'b0) begin
        n_bad++;
        $display("FAIL sticky_hold%0d: got mfa=%b grant=%b fmfc=%b dmfc=%b want all 0", i, M_MFA, GRANT, F_MFC, D_MFC);
      end
      if (i < 2) tick();
    end
    M_MFC = 1'b0;
    wait_grant(6, ok, cyc);
    n_cmp++;
    begin
      port_t e = sb.pop_front();
      if (!ok || cyc != 2 || port_obs() !== e) begin
        n_bad++;
        $display("FAIL sticky_f: got %h after %0d cycles want %h after 2", port_obs(), cyc, e);
      end
    end
    complete(1'b0, 1, 32'h0, f_m, d_m, r);
    M_MFC = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok; int cyc; bit saw_mfc;
    D_ADDR = 32'h700; D_READ_WRITE = 1'b0; D_WORD_BYTE = 1'b1; D_WDATA = 32'hDEADBEEF;
    D_MFA = 1'b1;
    exp_wdata = 32'hDEADBEEF;
    sb.push_back('{grant: 2'b10, addr: 32'h700, rw: 1'b0, wb: 1'b1, wdata: exp_wdata});
    wait_grant(4, ok, cyc);
    begin
      port_t e = sb.pop_front();
      n_cmp++;
      if (!ok || port_obs() !== e) begin
        n_bad++;
        $display("FAIL abort_latch: got %h want %h", port_obs(), e);
      end
      D_ADDR = 32'h7FC; D_WDATA = 32'h0; D_READ_WRITE = 1'b1; D_WORD_BYTE = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (port_obs() !== e) begin
        n_bad++;
        $display("FAIL abort_stable: got %h want %h", port_obs(), e);
      end
    end
    D_MFA = 1'b0;
    saw_mfc = 1'b0;
    tick();
    n_cmp++;
    if ({M_MFA, GRANT} !== 3'b0) begin
      n_bad++;
      $display("FAIL abort_release: got mfa=%b grant=%b want 0", M_MFA, GRANT);
    end
    for (int i = 0; i < 3; i++) begin
      if (D_MFC !== 1'b0) saw_mfc = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw_mfc || GRANT !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_no_mfc: got saw_mfc=%b grant=%b want 0/00", saw_mfc, GRANT);
    end
  endtask

  task automatic test_reset_mid_grant();
    bit ok; int cyc;
    D_ADDR = 32'h900; D_READ_WRITE = 1'b1; D_MFA = 1'b1;
    wait_grant(4, ok, cyc);
    n_cmp++;
    if (!ok || {M_MFA, GRANT} !== 3'b110) begin
      n_bad++;
      $display("FAIL rstmid_grant: got mfa=%b grant=%b want 1/10", M_MFA, GRANT);
    end
    #2;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({M_MFA, GRANT} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_async: got mfa=%b grant=%b want 0/00", M_MFA, GRANT);
    end
    D_MFA = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    n_cmp++;
    if (port_obs() !== '0 || {M_MFA, F_MFC, D_MFC, RDATA} !== 35'h0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got port=%h mfa=%b rdata=%h want all 0", port_obs(), M_MFA, RDATA);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_tie();
    test_back_to_back();
    test_sticky_mfc();
    test_abort();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
